// File: rtl/xor_tree_pkg.sv
// rtl/xor_tree_pkg.sv - shared constants, depth helper and stage control type for xor_tree_pipe_mux
package xor_tree_pkg;

  localparam int MAX_WIDTH = 256;

  // per-stage control that travels alongside the partial parity bits
  typedef struct packed {
    logic valid;
    logic mode;
  } stage_ctrl_t;

  function automatic int tree_depth(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/xor_tree_pipe_mux_if.sv
// rtl/xor_tree_pipe_mux_if.sv - upstream/downstream handshake bundle for xor_tree_pipe_mux
interface xor_tree_pipe_mux_if #(parameter int WIDTH = 16);

  logic             up_valid;
  logic             up_ready;
  logic [WIDTH-1:0] up_data;
  logic             up_odd;
  logic             down_valid;
  logic             down_ready;
  logic             down_parity;

  modport master (
    output up_valid, up_data, up_odd, down_ready,
    input  up_ready, down_valid, down_parity
  );

  modport slave (
    input  up_valid, up_data, up_odd, down_ready,
    output up_ready, down_valid, down_parity
  );

endinterface

// File: rtl/xor2_mux_cell.sv
// rtl/xor2_mux_cell.sv - 2-input XOR built from two 2:1 mux selections
module xor2_mux_cell (
  input  logic i_a,
  input  logic i_b,
  output logic o_y
);

  logic w_nb;

  // NOT b is picked from constants, then a chooses between b and NOT b
  always_comb begin
    w_nb = i_b ? 1'b0 : 1'b1;
    o_y  = i_a ? w_nb : i_b;
  end

endmodule

// File: rtl/xor_tree_pipe_mux.sv
// rtl/xor_tree_pipe_mux.sv - pipelined elastic XOR-reduction tree of mux cells; optional done_cnt under XOR_TREE_PIPE_CNT_EN
module xor_tree_pipe_mux
  import xor_tree_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic                clk,
  input logic                rst_n,
  xor_tree_pipe_mux_if.slave bus
`ifdef XOR_TREE_PIPE_CNT_EN
  ,
  output logic [15:0]        done_cnt
`endif
);

  localparam int DEPTH = tree_depth(WIDTH);
  localparam int PW    = 1 << DEPTH;

  // Tree nodes of all levels live in one vector: level k starts at PW - 2*(PW>>k)
  // and holds PW>>k bits, so the single root bit sits at PW-2.
  logic [PW-1:0]    w_pad;
  logic [PW-2:0]    w_cell;
  logic [PW-2:0]    w_ld;
  logic [PW-2:0]    r_tree;
  logic [DEPTH+1:1] w_adv;
  stage_ctrl_t      w_ctrl_src [1:DEPTH];
  stage_ctrl_t      r_ctrl     [1:DEPTH];

  // zero-extend the input to a full power-of-two tree
  always_comb begin
    w_pad              = '0;
    w_pad[WIDTH-1:0]   = bus.up_data;
  end

  // a stage may load when it is empty or when its successor is loading
  always_comb begin
    w_adv[DEPTH+1] = bus.down_ready;
    for (int k = DEPTH; k >= 1; k--) begin
      w_adv[k] = r_ctrl[k].valid ? w_adv[k+1] : 1'b1;
    end
  end

  // control source per stage: the upstream port feeds stage 1
  always_comb begin
    w_ctrl_src[1].valid = bus.up_valid;
    w_ctrl_src[1].mode  = bus.up_odd;
    for (int k = 2; k <= DEPTH; k++) begin
      w_ctrl_src[k] = r_ctrl[k-1];
    end
  end

  for (genvar k = 1; k <= DEPTH; k++) begin : g_lvl
    localparam int NO = PW >> k;
    localparam int OO = PW - 2 * NO;
    localparam int OI = PW - 4 * NO;
    for (genvar j = 0; j < NO; j++) begin : g_node
      logic w_a;
      logic w_b;
      if (k == 1) begin : g_src
        assign w_a = w_pad[2*j];
        assign w_b = w_pad[2*j+1];
      end else begin : g_src
        assign w_a = r_tree[OI+2*j];
        assign w_b = r_tree[OI+2*j+1];
      end
      xor2_mux_cell u_cell (
        .i_a (w_a),
        .i_b (w_b),
        .o_y (w_cell[OO+j])
      );
      assign w_ld[OO+j] = w_adv[k];
    end
  end

  // tree nodes load with their stage, otherwise hold under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tree <= '0;
    end else begin
      for (int i = 0; i < PW - 1; i++) begin
        r_tree[i] <= w_ld[i] ? w_cell[i] : r_tree[i];
      end
    end
  end

  // valid and mode ride through the stages with the data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= DEPTH; k++) begin
        r_ctrl[k] <= '0;
      end
    end else begin
      for (int k = 1; k <= DEPTH; k++) begin
        r_ctrl[k] <= w_adv[k] ? w_ctrl_src[k] : r_ctrl[k];
      end
    end
  end

  assign bus.up_ready   = w_adv[1];
  assign bus.down_valid = r_ctrl[DEPTH].valid;

  // odd mode inverts the root by XOR with the mode bit, still a mux cell
  xor2_mux_cell u_mode_cell (
    .i_a (r_tree[PW-2]),
    .i_b (r_ctrl[DEPTH].mode),
    .o_y (bus.down_parity)
  );

`ifdef XOR_TREE_PIPE_CNT_EN
  logic [15:0] r_done_cnt;
  logic        w_fire;

  assign w_fire = r_ctrl[DEPTH].valid ? bus.down_ready : 1'b0;

  // completed output transfers; wraps naturally at 16 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done_cnt <= '0;
    end else begin
      r_done_cnt <= w_fire ? r_done_cnt + 16'd1 : r_done_cnt;
    end
  end

  assign done_cnt = r_done_cnt;
`endif

endmodule
